// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, 15-entry register file written from W,
// register-ID generation and operand forwarding for valA/valB.
module decode_stage #(
  parameter int          NREG     = 15,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic [2:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [63:0] d_valC,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } dreg_t;

  localparam dreg_t BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, rA: RNONE, rB: RNONE,
                               valC: 64'h0, valP: 64'h0};

  dreg_t       dreg_q, dreg_d;
  logic [63:0] rf_q [NREG];

  always_comb begin
    dreg_d = dreg_q;
    if (!D_stall) begin
      if (D_bubble) dreg_d = BUBBLE;
      else dreg_d = '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB,
                      valC: f_valC, valP: f_valP};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dreg_q <= BUBBLE;
    else     dreg_q <= dreg_d;
  end

  // M port written second so it wins when both ports target the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'h0;
    end else begin
      if (W_dstE != RNONE && int'(W_dstE) < NREG) rf_q[W_dstE] <= W_valE;
      if (W_dstM != RNONE && int'(W_dstM) < NREG) rf_q[W_dstM] <= W_valM;
    end
  end

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (dreg_q.icode)
      4'h2: begin d_srcA = dreg_q.rA; d_dstE = dreg_q.rB; end
      4'h3: d_dstE = dreg_q.rB;
      4'h4: begin d_srcA = dreg_q.rA; d_srcB = dreg_q.rB; end
      4'h5: begin d_srcB = dreg_q.rB; d_dstM = dreg_q.rA; end
      4'h6: begin d_srcA = dreg_q.rA; d_srcB = dreg_q.rB; d_dstE = dreg_q.rB; end
      4'h8: begin d_srcB = RRSP; d_dstE = RRSP; end
      4'h9: begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; end
      4'hA: begin d_srcA = dreg_q.rA; d_srcB = RRSP; d_dstE = RRSP; end
      4'hB: begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; d_dstM = dreg_q.rA; end
      default: ;
    endcase
  end

  // Youngest producer first; RNONE never matches so it falls through to zero
  function automatic logic [63:0] fwd(input logic [3:0] src);
    if (src == RNONE)            return 64'h0;
    else if (src == e_dstE)      return e_valE;
    else if (src == M_dstM)      return m_valM;
    else if (src == M_dstE)      return M_valE;
    else if (src == W_dstM)      return W_valM;
    else if (src == W_dstE)      return W_valE;
    else if (int'(src) < NREG)   return rf_q[src];
    else                         return 64'h0;
  endfunction

  always_comb begin
    if (dreg_q.icode == 4'h7 || dreg_q.icode == 4'h8) d_valA = dreg_q.valP;
    else d_valA = fwd(d_srcA);
    d_valB = fwd(d_srcB);
  end

  assign d_stat  = dreg_q.stat;
  assign d_icode = dreg_q.icode;
  assign d_ifun  = dreg_q.ifun;
  assign d_valC  = dreg_q.valC;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the D register and register file.
module tb_decode_stage;
  localparam logic [63:0] RSP = 64'h0000_0000_0000_F000;

  logic        clk = 0;
  logic        rst, D_stall, D_bubble;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;

  int checks = 0, failures = 0;

  // behavioural model state
  logic [63:0] m_rf [15];
  logic [2:0]  md_stat;
  logic [3:0]  md_icode, md_ifun, md_rA, md_rB;
  logic [63:0] md_valC, md_valP;
  logic [3:0]  x_srcA, x_srcB, x_dstE, x_dstM;
  logic [63:0] x_valA, x_valB;

  decode_stage #(.NREG(15), .RSP_INIT(RSP)) dut (
    .clk(clk), .rst(rst), .D_stall(D_stall), .D_bubble(D_bubble),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB)
  );

  always #5 clk = ~clk;

  task automatic model_bubble();
    md_stat = 3'd1; md_icode = 4'h1; md_ifun = 4'h0; md_rA = 4'hF; md_rB = 4'hF;
    md_valC = 64'h0; md_valP = 64'h0;
  endtask

  // advance one clock and apply the same edge to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 15; i++) m_rf[i] = 64'h0;
      m_rf[4] = RSP;
      model_bubble();
    end else begin
      if (!D_stall) begin
        if (D_bubble) model_bubble();
        else begin
          md_stat = f_stat; md_icode = f_icode; md_ifun = f_ifun; md_rA = f_rA; md_rB = f_rB;
          md_valC = f_valC; md_valP = f_valP;
        end
      end
      if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
      if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
    end
    #1;
  endtask

  function automatic logic [63:0] m_operand(input logic [3:0] src);
    if (src == 4'hF)         return 64'h0;
    if (src == e_dstE)       return e_valE;
    if (src == M_dstM)       return m_valM;
    if (src == M_dstE)       return M_valE;
    if (src == W_dstM)       return W_valM;
    if (src == W_dstE)       return W_valE;
    return m_rf[src];
  endfunction

  task automatic model_eval();
    int ic;
    ic = int'(md_icode);
    x_srcA = (ic inside {2, 4, 6, 10}) ? md_rA : (ic inside {9, 11}) ? 4'h4 : 4'hF;
    x_srcB = (ic inside {4, 5, 6}) ? md_rB : (ic inside {8, 9, 10, 11}) ? 4'h4 : 4'hF;
    x_dstE = (ic inside {2, 3, 6}) ? md_rB : (ic inside {8, 9, 10, 11}) ? 4'h4 : 4'hF;
    x_dstM = (ic inside {5, 11}) ? md_rA : 4'hF;
    x_valA = (ic inside {7, 8}) ? md_valP : m_operand(x_srcA);
    x_valB = m_operand(x_srcB);
  endtask

  task automatic idle_inputs();
    rst = 0; D_stall = 0; D_bubble = 0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_valE = 64'h0; W_valM = 64'h0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    f_stat = 3'd1; f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
  endtask

  task automatic test_reset();
    idle_inputs();
    fetch(4'h6, 4'h2, 4'h3, 64'hAA, 64'hBB);
    rst = 1; W_dstE = 4'h3; W_valE = 64'd99;
    tick(); tick();
    rst = 0; W_dstE = 4'hF; W_valE = 64'h0;
    checks++;
    if ({d_stat, d_icode, d_ifun} !== {3'd1, 4'h1, 4'h0}) begin
      failures++; $display("FAIL reset_ctrl got stat/icode/ifun=%h/%h/%h want 1/1/0", d_stat, d_icode, d_ifun);
    end
    checks++;
    if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin
      failures++; $display("FAIL reset_ids got %h%h%h%h want ffff", d_srcA, d_srcB, d_dstE, d_dstM);
    end
    checks++;
    if ({d_valA, d_valB} !== 128'h0) begin
      failures++; $display("FAIL reset_vals got valA=%h valB=%h want 0", d_valA, d_valB);
    end
    fetch(4'hA, 4'h3, 4'hF, 64'h0, 64'h0);  // pushq %rbx
    tick();
    checks++;
    if (d_valB !== RSP) begin
      failures++; $display("FAIL reset_rsp got %h want %h", d_valB, RSP);
    end
    checks++;
    if (d_valA !== 64'h0) begin
      failures++; $display("FAIL reset_write_discard got %h want 0", d_valA);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    W_dstE = 4'h3; W_valE = 64'h1234;
    tick();
    W_dstE = 4'hF; W_valE = 64'h0;
    fetch(4'h6, 4'h3, 4'h5, 64'h0, 64'h0);
    tick();
    checks++;
    if (d_valA !== 64'h1234) begin
      failures++; $display("FAIL wr_rd_valA got %h want 1234", d_valA);
    end
    checks++;
    if ({d_srcB, d_dstE} !== {4'h5, 4'h5}) begin
      failures++; $display("FAIL wr_rd_ids got srcB=%h dstE=%h want 5/5", d_srcB, d_dstE);
    end
  endtask

  task automatic test_forward();
    idle_inputs();
    fetch(4'h6, 4'h2, 4'h7, 64'h0, 64'h0);
    tick();
    e_dstE = 4'h2; e_valE = 64'd5; M_dstM = 4'h2; m_valM = 64'd7;
    #1;
    checks++;
    if (d_valA !== 64'd5) begin
      failures++; $display("FAIL fwd_e got %h want 5", d_valA);
    end
    e_dstE = 4'hF;
    #1;
    checks++;
    if (d_valA !== 64'd7) begin
      failures++; $display("FAIL fwd_m got %h want 7", d_valA);
    end
    W_dstM = 4'h2; W_valM = 64'd9;
    #1;
    checks++;
    if (d_valA !== 64'd7) begin
      failures++; $display("FAIL fwd_m_over_w got %h want 7", d_valA);
    end
    M_dstM = 4'hF;
    #1;
    checks++;
    if (d_valA !== 64'd9) begin
      failures++; $display("FAIL fwd_w got %h want 9", d_valA);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_control();
    idle_inputs();
    fetch(4'h8, 4'hF, 4'hF, 64'h100, 64'h40);
    e_dstE = 4'h4; e_valE = 64'hDEAD;  // must not override valP
    tick();
    checks++;
    if (d_valA !== 64'h40) begin
      failures++; $display("FAIL call_valA got %h want 40", d_valA);
    end
    checks++;
    if ({d_srcB, d_dstE, d_dstM} !== {4'h4, 4'h4, 4'hF}) begin
      failures++; $display("FAIL call_ids got srcB=%h dstE=%h dstM=%h want 4/4/f", d_srcB, d_dstE, d_dstM);
    end
    e_dstE = 4'hF;
    fetch(4'h9, 4'hF, 4'hF, 64'h0, 64'h0);
    tick();
    checks++;
    if ({d_srcA, d_srcB} !== {4'h4, 4'h4}) begin
      failures++; $display("FAIL ret_ids got srcA=%h srcB=%h want 4/4", d_srcA, d_srcB);
    end
    fetch(4'hC, 4'h1, 4'h2, 64'h0, 64'h0);
    tick();
    checks++;
    if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin
      failures++; $display("FAIL bad_icode_ids got %h%h%h%h want ffff", d_srcA, d_srcB, d_dstE, d_dstM);
    end
  endtask

  task automatic test_stall_bubble();
    idle_inputs();
    fetch(4'h3, 4'hF, 4'h7, 64'h55, 64'h0A);
    tick();
    D_stall = 1;
    fetch(4'h6, 4'h1, 4'h2, 64'h77, 64'h0B);
    tick();
    checks++;
    if ({d_icode, d_valC, d_dstE} !== {4'h3, 64'h55, 4'h7}) begin
      failures++; $display("FAIL stall_hold got icode=%h valC=%h dstE=%h want 3/55/7", d_icode, d_valC, d_dstE);
    end
    D_bubble = 1;
    tick();
    checks++;
    if ({d_icode, d_valC} !== {4'h3, 64'h55}) begin
      failures++; $display("FAIL stall_over_bubble got icode=%h valC=%h want 3/55", d_icode, d_valC);
    end
    D_stall = 0;
    tick();
    checks++;
    if ({d_icode, d_valC, d_dstE} !== {4'h1, 64'h0, 4'hF}) begin
      failures++; $display("FAIL bubble got icode=%h valC=%h dstE=%h want 1/0/f", d_icode, d_valC, d_dstE);
    end
    D_bubble = 0;
    tick();
    rst = 1; D_stall = 1;
    tick();
    checks++;
    if ({d_icode, d_valC} !== {4'h1, 64'h0}) begin
      failures++; $display("FAIL rst_over_stall got icode=%h valC=%h want 1/0", d_icode, d_valC);
    end
    idle_inputs();
  endtask

  task automatic test_dual_write();
    idle_inputs();
    W_dstE = 4'h6; W_dstM = 4'h6; W_valE = 64'd1; W_valM = 64'd2;
    tick();
    W_dstE = 4'hF; W_dstM = 4'hF; W_valE = 64'hBAD; W_valM = 64'hBAD;
    fetch(4'h6, 4'h6, 4'h6, 64'h0, 64'h0);
    tick();
    checks++;
    if (d_valA !== 64'd2) begin
      failures++; $display("FAIL dual_write got %h want 2", d_valA);
    end
    tick();
    checks++;
    if ({d_valA, d_valB} !== {64'd2, 64'd2}) begin
      failures++; $display("FAIL rnone_write got valA=%h valB=%h want 2/2", d_valA, d_valB);
    end
  endtask

  function automatic logic [3:0] rnd_dst();
    return ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      D_stall  = ($urandom_range(0, 5) == 0);
      D_bubble = ($urandom_range(0, 6) == 0);
      f_stat  = 3'($urandom_range(0, 7));
      f_icode = 4'($urandom_range(0, 15));
      f_ifun  = 4'($urandom_range(0, 15));
      f_rA    = 4'($urandom_range(0, 15));
      f_rB    = 4'($urandom_range(0, 15));
      f_valC  = {$urandom, $urandom};
      f_valP  = {$urandom, $urandom};
      e_dstE = rnd_dst(); M_dstE = rnd_dst(); M_dstM = rnd_dst();
      W_dstE = rnd_dst(); W_dstM = rnd_dst();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
      W_valM = {$urandom, $urandom};
      #1;
      model_eval();
      checks++;
      if ({d_stat, d_icode, d_ifun, d_valC, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB} !==
          {md_stat, md_icode, md_ifun, md_valC, x_srcA, x_srcB, x_dstE, x_dstM, x_valA, x_valB}) begin
        failures++;
        $display("FAIL rand[%0d] got ic=%h ids=%h%h%h%h valA=%h valB=%h want ic=%h ids=%h%h%h%h valA=%h valB=%h",
                 n, d_icode, d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB,
                 md_icode, x_srcA, x_srcB, x_dstE, x_dstM, x_valA, x_valB);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    fetch(4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    test_reset();
    test_write_read();
    test_forward();
    test_control();
    test_stall_bubble();
    test_dual_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
